// File: rtl/ifc_or_arbiter_if.sv
// Bundle of the signals between the round-robin arbiter, its requesters,
// the response consumer and the shared ifc_or unit's a/b/y methods.
interface ifc_or_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
);
  logic [N_REQ-1:0] req_valid;
  logic [N_REQ-1:0] req_a;
  logic [N_REQ-1:0] req_b;
  logic [N_REQ-1:0] req_grant;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [ID_W-1:0]  rsp_id;
  logic             rsp_data;
  logic             rsp_err;
  logic             a_data;
  logic             a_en;
  logic             a_rdy;
  logic             b_data;
  logic             b_en;
  logic             b_rdy;
  logic             y_en;
  logic             y_data;
  logic             y_rdy;

  // Arbiter side.
  modport master (
    input  req_valid, req_a, req_b, rsp_ready, a_rdy, b_rdy, y_data, y_rdy,
    output req_grant, rsp_valid, rsp_id, rsp_data, rsp_err,
           a_data, a_en, b_data, b_en, y_en
  );

  // Requesters, response consumer and shared unit side.
  modport slave (
    output req_valid, req_a, req_b, rsp_ready, a_rdy, b_rdy, y_data, y_rdy,
    input  req_grant, rsp_valid, rsp_id, rsp_data, rsp_err,
           a_data, a_en, b_data, b_en, y_en
  );
endinterface

// File: rtl/ifc_or_arbiter.sv
// Round-robin arbiter/sequencer sharing one ifc_or unit among N_REQ
// requesters; one operation in flight at a time.
//
// state  | meaning
// IDLE   | arbitrate, grant and latch one requester's operands
// ISSUE  | fire the a and b put methods once each
// WAIT_Y | wait for y_rdy (or timeout) and capture the result
// RESP   | present the response until rsp_ready
module ifc_or_arbiter #(
  parameter int N_REQ   = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  ifc_or_arbiter_if.master    bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ISSUE  = 2'd1;
  localparam logic [1:0] S_WAIT_Y = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [1:0]       r_state;
  logic [ID_W-1:0]  r_ptr;
  logic [ID_W-1:0]  r_idx;
  logic             r_a;
  logic             r_b;
  logic             r_sent_a;
  logic             r_sent_b;
  logic [CNT_W-1:0] r_cnt;
  logic [ID_W-1:0]  r_rsp_id;
  logic             r_rsp_data;
  logic             r_rsp_err;

  logic [2*N_REQ-1:0] w_dbl;
  logic               w_found;
  logic [ID_W-1:0]    w_win;
  logic [N_REQ-1:0]   w_oh;
  logic [ID_W-1:0]    w_ptr_nxt;
  logic               w_a_fire;
  logic               w_b_fire;
  logic               w_ab_done;
  logic               w_y_fire;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               w_tmo;

  // Rotate requests so bit 0 is rr_ptr, take the first set bit, map back.
  always_comb begin
    int k;
    k       = 0;
    w_found = 1'b0;
    w_win   = '0;
    w_oh    = '0;
    w_dbl   = {bus.req_valid, bus.req_valid} >> r_ptr;
    for (int i = 0; i < N_REQ; i++) begin
      if (!w_found && w_dbl[i]) begin
        w_found = 1'b1;
        k = int'(r_ptr) + i;
        if (k >= N_REQ) k = k - N_REQ;
        w_win = ID_W'(k);
      end
    end
    for (int j = 0; j < N_REQ; j++) begin
      w_oh[j] = w_found && (ID_W'(j) == w_win);
    end
  end

  assign w_ptr_nxt = (w_win == ID_W'(N_REQ - 1)) ? '0 : w_win + 1'b1;

  assign w_a_fire  = (r_state == S_ISSUE) && bus.a_rdy && !r_sent_a;
  assign w_b_fire  = (r_state == S_ISSUE) && bus.b_rdy && !r_sent_b;
  assign w_ab_done = (r_sent_a || w_a_fire) && (r_sent_b || w_b_fire);
  assign w_y_fire  = (r_state == S_WAIT_Y) && bus.y_rdy;
  assign w_cnt_nxt = r_cnt + 1'b1;
  assign w_tmo     = (TIMEOUT != 0) && (w_cnt_nxt == CNT_W'(TIMEOUT));

  // Grant is combinational in IDLE; gated by reset so every output is 0 while held.
  assign bus.req_grant = (r_state == S_IDLE && i_rst_n) ? w_oh : '0;
  assign bus.a_en      = w_a_fire;
  assign bus.b_en      = w_b_fire;
  assign bus.a_data    = (r_state == S_ISSUE) && r_a;
  assign bus.b_data    = (r_state == S_ISSUE) && r_b;
  assign bus.y_en      = w_y_fire;
  assign bus.rsp_valid = (r_state == S_RESP);
  assign bus.rsp_id    = r_rsp_id;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.rsp_err   = r_rsp_err;

  // Sequencer: arbitration, method firing, result capture and response hold.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_ptr      <= '0;
      r_idx      <= '0;
      r_a        <= 1'b0;
      r_b        <= 1'b0;
      r_sent_a   <= 1'b0;
      r_sent_b   <= 1'b0;
      r_cnt      <= '0;
      r_rsp_id   <= '0;
      r_rsp_data <= 1'b0;
      r_rsp_err  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_a      <= |(bus.req_a & w_oh);
            r_b      <= |(bus.req_b & w_oh);
            r_idx    <= w_win;
            r_ptr    <= w_ptr_nxt;
            r_sent_a <= 1'b0;
            r_sent_b <= 1'b0;
            r_state  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (w_ab_done) begin
            r_sent_a <= 1'b0;
            r_sent_b <= 1'b0;
            r_cnt    <= '0;
            r_state  <= S_WAIT_Y;
          end else begin
            if (w_a_fire) r_sent_a <= 1'b1;
            if (w_b_fire) r_sent_b <= 1'b1;
          end
        end
        S_WAIT_Y: begin
          // A real result beats a timeout landing in the same cycle.
          if (bus.y_rdy) begin
            r_rsp_data <= bus.y_data;
            r_rsp_err  <= 1'b0;
            r_rsp_id   <= r_idx;
            r_state    <= S_RESP;
          end else if (w_tmo) begin
            r_rsp_data <= 1'b0;
            r_rsp_err  <= 1'b1;
            r_rsp_id   <= r_idx;
            r_state    <= S_RESP;
          end else begin
            r_cnt <= w_cnt_nxt;
          end
        end
        default: begin
          if (bus.rsp_ready) r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/ifc_or_arbiter.md
Name: ifc_or_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one ifc_or-style unit among N_REQ requesters.
- Each unit has three method ports: a (put), b (put) and y (get), each with an en/rdy handshake.
- Accepts one requester's operand pair and drives the a and b methods.
- Collects the y result, then returns it with the requester id over a valid/ready response port.
- Sits between requester logic and the shared unit; one operation is in flight at a time.

Parameters:
- N_REQ, 4: number of requesters, 2..16.
- ID_W, 2: response id width, at least clog2(N_REQ).
- TIMEOUT, 64: cycles to wait for y_rdy before aborting; 0 disables the timeout.

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  reset, asynchronous, active-low.
- req_valid  in  N_REQ  per-requester request pending.
- req_a  in  N_REQ  per-requester a operand bit.
- req_b  in  N_REQ  per-requester b operand bit.
- req_grant  out  N_REQ  one-hot, one-cycle pulse: request accepted.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  ID_W  index of the served requester.
- rsp_data  out  1  result bit.
- rsp_err  out  1  response produced by timeout.
- a_data  out  1  to unit a method.
- a_en  out  1  to unit a method.
- a_rdy  in  1  from unit a method.
- b_data  out  1  to unit b method.
- b_en  out  1  to unit b method.
- b_rdy  in  1  from unit b method.
- y_en  out  1  to unit y method.
- y_data  in  1  from unit y method.
- y_rdy  in  1  from unit y method.

Behaviour:
- Reset (RST_N=0, async): state=IDLE; rr_ptr=0.
  - All outputs 0: req_grant, rsp_valid, rsp_id, rsp_data, rsp_err, a_en, b_en, a_data, b_data, y_en.
  - Internal sent_a, sent_b and timeout counter cleared.
  - Reset mid-operation abandons the operation; no response is produced.
- FSM states: IDLE, ISSUE, WAIT_Y, RESP.
- IDLE, arbitration:
  - If any req_valid bit is set, pick the first set bit searching upward from rr_ptr, wrapping at N_REQ-1 to 0.
  - Latch its req_a, req_b and index; pulse req_grant[winner] for exactly that cycle.
  - Set rr_ptr=(winner+1) mod N_REQ. Next state=ISSUE.
  - If no request is pending, stay in IDLE; rr_ptr is unchanged.
- Grant and queueing:
  - Requesters hold req_valid until they see their grant.
  - A requester not granted stays pending with no loss.
  - No grant is issued in any state other than IDLE.
- ISSUE:
  - a_data and b_data are the latched operands, driven throughout ISSUE.
  - a_en = a_rdy & !sent_a; b_en = b_rdy & !sent_b. Both methods may fire in the same cycle.
  - sent_a/sent_b set on firing.
  - When both methods have fired (same-cycle firing counts), next state=WAIT_Y; clear sent flags and the timeout counter.
  - a_rdy or b_rdy held low stalls ISSUE indefinitely; no timeout applies in ISSUE.
- WAIT_Y:
  - y_en = y_rdy, combinational, only in WAIT_Y.
  - On y_rdy: capture y_data into rsp_data, rsp_err=0, rsp_id=latched index; next state=RESP.
  - Otherwise increment the counter. If TIMEOUT!=0 and the counter reaches TIMEOUT, go to RESP with rsp_data=0 and rsp_err=1.
  - y_rdy in the same cycle the counter reaches TIMEOUT: the y result wins, and rsp_err=0.
- RESP:
  - rsp_valid=1; rsp_id, rsp_data and rsp_err are held stable while rsp_valid=1 and rsp_ready=0.
  - On rsp_valid & rsp_ready: next state=IDLE.
  - rsp_valid drops the following cycle; rsp_data, rsp_id and rsp_err hold their last values.
- Latency, with unit rdy signals always high: grant at cycle T, a_en/b_en at T+1, y_en at the earliest T+2, rsp_valid at T+3.
  - Minimum one-operation turnaround is 4 cycles before the next grant.
- Enable pulse rules: a_en, b_en and y_en are never asserted when the corresponding rdy=0. Each fires exactly once per operation.

Test Plan:
- Single request: req_valid=0001, a=1, b=0; unit always rdy, y_data=1 at y_rdy.
  - Expect req_grant=0001 at T, a_en=b_en=1 at T+1, y_en at T+2.
  - Expect rsp_valid at T+3 with rsp_id=0, rsp_data=1, rsp_err=0.
- Fairness: req_valid=1111 held continuously, re-asserted after each grant.
  - Expect grant order 0,1,2,3,0; rsp_id sequence matches.
- Split handshake: a_rdy=1 but b_rdy=0 for 5 cycles, then b_rdy=1.
  - Expect a_en exactly once at T+1 and b_en exactly once when b_rdy rises; no duplicate a_en.
- Response backpressure: rsp_ready=0 for 10 cycles.
  - Expect rsp_valid, rsp_id and rsp_data stable throughout.
  - Expect no new grant while req_valid=0010 is pending; grant 0010 the cycle after the handshake plus the IDLE cycle.
- Timeout, TIMEOUT=8: y_rdy held 0.
  - Expect the RESP entry on the 8th WAIT_Y cycle with rsp_err=1, rsp_data=0, and y_en never asserted.
- Reset mid-op: deassert RST_N during WAIT_Y.
  - Expect all outputs 0 immediately (asynchronously); after release, the next grant goes to requester 0 if it is pending.
